samp_resolve_tile: RTL and testbench

- Receiving end of the rasterizer's hit-sample stream. Accepts per-sample hits from the sample stage and depth-tests each one against a per-tile, per-sample Z/color store.
- On a flush request, resolves each pixel by box-averaging its NUM_SAMPLES colors and streams the resolved pixels out over a ready/valid port.
- While it is resolving, it stalls the rasterizer through an active-low halt.

---
 rtl/samp_resolve_tile_pkg.sv | 40 ++++
 rtl/samp_resolve_tile_avg.sv | 27 ++
 rtl/samp_resolve_tile.sv | 139 +++++++++++++
 tb/tb_samp_resolve_tile.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/samp_resolve_tile_pkg.sv
// Shared rasterizer parameters and types (rast_params) used by the sample
// resolve tile and its averaging sub-block.
//   - geometry/precision constants (SIGFIG, RADIX, AXIS, COLORS, NUM_SAMPLES)
//   - tile size (TILE_W, TILE_H) and derived address widths
//   - sample_entry_t: one stored sample (depth plus color channels)
//   - Z_FAR: depth of an empty sample (farthest possible)
package rast_params;

    localparam int SIGFIG      = 24;
    localparam int RADIX       = 10;
    localparam int AXIS        = 3;
    localparam int COLORS      = 3;
    localparam int NUM_SAMPLES = 4;
    localparam int TILE_W      = 8;
    localparam int TILE_H      = 8;

    localparam int SIDX_W    = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
    localparam int AVG_SHIFT = $clog2(NUM_SAMPLES);
    localparam int PX_W      = $clog2(TILE_W);
    localparam int PY_W      = $clog2(TILE_H);
    localparam int PIX_W     = PX_W + PY_W;
    localparam int NUM_PIX   = TILE_W * TILE_H;

    typedef logic [SIGFIG-1:0] value_t;
    typedef value_t [COLORS-1:0] color_t;

    typedef struct packed {
        value_t z;
        color_t color;
    } sample_entry_t;

    localparam value_t        Z_FAR       = '1;
    localparam sample_entry_t EMPTY_ENTRY = '{z: Z_FAR, color: '0};

    typedef enum logic {
        ACCEPT,
        RESOLVE
    } state_t;

endpackage

// File: rtl/samp_resolve_tile_avg.sv
// samp_avg: combinational box filter for one pixel.
//   samples : NUM_SAMPLES colors of the pixel being resolved
//   avg     : per-channel sum of the samples divided by NUM_SAMPLES
// The sum is widened by AVG_SHIFT bits so it cannot overflow, and the
// division is a right shift, which truncates toward zero.
module samp_avg
    import rast_params::*;
(
    input  color_t [NUM_SAMPLES-1:0] samples,
    output color_t                   avg
);

    localparam int SUM_W = SIGFIG + AVG_SHIFT;

    logic [SUM_W-1:0] sum [COLORS];

    always_comb begin
        for (int c = 0; c < COLORS; c++) begin
            sum[c] = '0;
            for (int s = 0; s < NUM_SAMPLES; s++) begin
                sum[c] = sum[c] + SUM_W'(samples[s][c]);
            end
            avg[c] = SIGFIG'(sum[c] >> AVG_SHIFT);
        end
    end

endmodule

// File: rtl/samp_resolve_tile.sv
// samp_resolve_tile: per-tile multisample depth test and resolve.
//   clk, rst      : clock, asynchronous active-high reset
//   hit_valid     : a hit sample is present on hit_pos/hit_color/hit_sidx
//   hit_pos       : fixed-point x, y, z of the sample
//   hit_color     : sample color
//   hit_sidx      : sample slot within the pixel
//   halt_RnnnnL   : low while resolving; upstream must hold its hits
//   flush_req     : pulse to resolve the tile and clear it
//   pix_valid/pix_ready, pix_x, pix_y, pix_color : resolved pixel stream
//   flush_done    : one-cycle pulse after the last pixel is accepted
module samp_resolve_tile
    import rast_params::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          hit_valid,
    input  logic [AXIS-1:0][SIGFIG-1:0]   hit_pos,
    input  logic [COLORS-1:0][SIGFIG-1:0] hit_color,
    input  logic [SIDX_W-1:0]             hit_sidx,
    output logic                          halt_RnnnnL,
    input  logic                          flush_req,
    output logic                          pix_valid,
    input  logic                          pix_ready,
    output logic [PX_W-1:0]               pix_x,
    output logic [PY_W-1:0]               pix_y,
    output logic [COLORS-1:0][SIGFIG-1:0] pix_color,
    output logic                          flush_done
);

    sample_entry_t store [NUM_PIX][NUM_SAMPLES];

    state_t                   state;
    state_t                   state_next;
    logic [PIX_W-1:0]         pix_cnt;
    logic [PIX_W-1:0]         hit_addr;
    logic                     hit_wins;
    logic                     pix_take;
    logic                     last_pix;
    color_t [NUM_SAMPLES-1:0] avg_in;
    color_t                   avg_out;
    logic                     unused_hit_bits;

    // Only the low integer bits of x/y address the tile, so positions wrap
    // modulo the tile size. Pixel index is raster order with x fastest.
    assign hit_addr = {hit_pos[1][RADIX +: PY_W], hit_pos[0][RADIX +: PX_W]};
    assign unused_hit_bits = ^{hit_pos[0], hit_pos[1]};

    // Strictly nearer wins; an equal depth keeps the existing sample.
    assign hit_wins = (state == ACCEPT) && hit_valid &&
                      (hit_pos[2] < store[hit_addr][hit_sidx].z);
    assign pix_take = (state == RESOLVE) && pix_valid && pix_ready;
    assign last_pix = (pix_cnt == PIX_W'(NUM_PIX - 1));

    always_comb begin
        for (int s = 0; s < NUM_SAMPLES; s++) begin
            avg_in[s] = store[pix_cnt][s].color;
        end
    end

    samp_avg u_avg (
        .samples (avg_in),
        .avg     (avg_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCEPT;
        end else begin
            state <= state_next;
        end
    end

    // Leave RESOLVE only when the final pixel is handed off.
    always_comb begin
        state_next  = state;
        halt_RnnnnL = 1'b1;
        case (state)
            ACCEPT: begin
                if (flush_req) begin
                    state_next = RESOLVE;
                end
            end
            RESOLVE: begin
                halt_RnnnnL = 1'b0;
                if (pix_take && last_pix) begin
                    state_next = ACCEPT;
                end
            end
            default: state_next = ACCEPT;
        endcase
    end

    // Output stage alternates load / handshake, so each pixel occupies at
    // least two cycles; registered outputs hold steady while pix_ready is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt    <= '0;
            pix_valid  <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_color  <= '0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            if (state == ACCEPT) begin
                pix_cnt   <= '0;
                pix_valid <= 1'b0;
            end else if (pix_take) begin
                pix_valid  <= 1'b0;
                pix_cnt    <= pix_cnt + 1'b1;
                flush_done <= last_pix;
            end else if (!pix_valid) begin
                pix_valid <= 1'b1;
                pix_x     <= pix_cnt[PX_W-1:0];
                pix_y     <= pix_cnt[PIX_W-1:PX_W];
                pix_color <= avg_out;
            end
        end
    end

    // Sample store: depth-tested writes while accepting, per-pixel clear as
    // each resolved pixel is accepted downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PIX; i++) begin
                for (int s = 0; s < NUM_SAMPLES; s++) begin
                    store[i][s] <= EMPTY_ENTRY;
                end
            end
        end else if (hit_wins) begin
            store[hit_addr][hit_sidx] <= '{z: hit_pos[2], color: hit_color};
        end else if (pix_take) begin
            for (int s = 0; s < NUM_SAMPLES; s++) begin
                store[pix_cnt][s] <= EMPTY_ENTRY;
            end
        end
    end

endmodule

// File: tb/tb_samp_resolve_tile.sv
module tb_samp_resolve_tile;
    import rast_params::*;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          hit_valid;
    logic [AXIS-1:0][SIGFIG-1:0]   hit_pos;
    logic [COLORS-1:0][SIGFIG-1:0] hit_color;
    logic [SIDX_W-1:0]             hit_sidx;
    logic                          halt_RnnnnL;
    logic                          flush_req;
    logic                          pix_valid;
    logic                          pix_ready;
    logic [PX_W-1:0]               pix_x;
    logic [PY_W-1:0]               pix_y;
    logic [COLORS-1:0][SIGFIG-1:0] pix_color;
    logic                          flush_done;

    int checks = 0;
    int errors = 0;

    samp_resolve_tile dut (
        .clk         (clk),
        .rst         (rst),
        .hit_valid   (hit_valid),
        .hit_pos     (hit_pos),
        .hit_color   (hit_color),
        .hit_sidx    (hit_sidx),
        .halt_RnnnnL (halt_RnnnnL),
        .flush_req   (flush_req),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_color   (pix_color),
        .flush_done  (flush_done)
    );

    always #5 clk = ~clk;

    // Reference tile: nearest-sample table per pixel/slot.
    logic [SIGFIG-1:0] mz  [NUM_PIX][NUM_SAMPLES];
    logic [SIGFIG-1:0] mc  [NUM_PIX][NUM_SAMPLES][COLORS];
    logic [SIGFIG-1:0] obs [NUM_PIX][COLORS];

    typedef struct {
        string       name;
        logic [23:0] xp;
        logic [23:0] yp;
        logic [23:0] zv;
        logic [23:0] r;
        int          sidx;
        int          ex;
        int          ey;
        logic [23:0] er;
    } vec_t;

    vec_t vecs [6];

    function automatic void model_clear();
        for (int i = 0; i < NUM_PIX; i++) begin
            for (int s = 0; s < NUM_SAMPLES; s++) begin
                mz[i][s] = {SIGFIG{1'b1}};
                for (int c = 0; c < COLORS; c++) mc[i][s][c] = '0;
            end
        end
    endfunction

    function automatic void model_hit(input logic [SIGFIG-1:0] xp, input logic [SIGFIG-1:0] yp,
                                      input logic [SIGFIG-1:0] zv,
                                      input logic [COLORS-1:0][SIGFIG-1:0] col, input int sidx);
        int px;
        int py;
        int idx;
        px  = int'(xp >> RADIX) % TILE_W;
        py  = int'(yp >> RADIX) % TILE_H;
        idx = py * TILE_W + px;
        if (zv < mz[idx][sidx]) begin
            mz[idx][sidx] = zv;
            for (int c = 0; c < COLORS; c++) mc[idx][sidx][c] = col[c];
        end
    endfunction

    function automatic logic [COLORS-1:0][SIGFIG-1:0] exp_color(input int p);
        logic [COLORS-1:0][SIGFIG-1:0] res;
        longint sum;
        for (int c = 0; c < COLORS; c++) begin
            sum = 0;
            for (int s = 0; s < NUM_SAMPLES; s++) sum += longint'(mc[p][s][c]);
            res[c] = SIGFIG'(sum / NUM_SAMPLES);
        end
        return res;
    endfunction

    function automatic logic [COLORS-1:0][SIGFIG-1:0] mk_color(input logic [SIGFIG-1:0] r,
                                                              input logic [SIGFIG-1:0] g,
                                                              input logic [SIGFIG-1:0] b);
        logic [COLORS-1:0][SIGFIG-1:0] res;
        res    = '0;
        res[0] = r;
        res[1] = g;
        res[2] = b;
        return res;
    endfunction

    task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Present one hit for one cycle while the tile is accepting.
    task automatic applyStimulus(input logic [SIGFIG-1:0] xp, input logic [SIGFIG-1:0] yp,
                                 input logic [SIGFIG-1:0] zv,
                                 input logic [COLORS-1:0][SIGFIG-1:0] col, input int sidx);
        hit_valid  = 1'b1;
        hit_pos[0] = xp;
        hit_pos[1] = yp;
        hit_pos[2] = zv;
        hit_color  = col;
        hit_sidx   = SIDX_W'(sidx);
        model_hit(xp, yp, zv, col, sidx);
        @(posedge clk);
        #1;
        hit_valid = 1'b0;
    endtask

    task automatic random_hits(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(SIGFIG'($urandom), SIGFIG'($urandom), SIGFIG'($urandom_range(0, 255)),
                          mk_color(SIGFIG'($urandom), SIGFIG'($urandom), SIGFIG'($urandom)),
                          int'($urandom_range(0, NUM_SAMPLES - 1)));
        end
    endtask

    // Pulse flush_req and consume the resolved stream, checking every pixel.
    task automatic run_flush(input bit random_ready, input int stall_at, input int abort_at,
                             input bit inject, input bit cohit);
        int hs;
        int cycles;
        int stall_cnt;
        bit finished;
        bit halt_bad;
        flush_req = 1'b1;
        if (cohit) begin
            hit_valid = 1'b1;
            model_hit(hit_pos[0], hit_pos[1], hit_pos[2], hit_color, int'(hit_sidx));
        end
        @(posedge clk);
        #1;
        flush_req = 1'b0;
        hit_valid = 1'b0;
        hs        = 0;
        cycles    = 0;
        stall_cnt = 0;
        finished  = 1'b0;
        halt_bad  = 1'b0;
        while (!finished && cycles < 1000) begin
            if (flush_done) begin
                finished = 1'b1;
            end else begin
                if (halt_RnnnnL !== 1'b0) halt_bad = 1'b1;
                if (abort_at == hs && pix_valid) begin
                    #2;
                    rst = 1'b1;
                    #1;
                    checkOutput("abort_pix_valid", 96'(pix_valid), 96'(0));
                    checkOutput("abort_pix_x", 96'(pix_x), 96'(0));
                    checkOutput("abort_pix_y", 96'(pix_y), 96'(0));
                    checkOutput("abort_pix_color", 96'(pix_color), 96'(0));
                    checkOutput("abort_flush_done", 96'(flush_done), 96'(0));
                    checkOutput("abort_halt", 96'(halt_RnnnnL), 96'(1));
                    @(posedge clk);
                    #1;
                    rst       = 1'b0;
                    pix_ready = 1'b0;
                    hit_valid = 1'b0;
                    model_clear();
                    return;
                end
                if (inject) begin
                    hit_valid  = 1'b1;
                    hit_pos[0] = SIGFIG'(7 << RADIX);
                    hit_pos[1] = SIGFIG'(7 << RADIX);
                    hit_pos[2] = SIGFIG'(1);
                    hit_color  = mk_color(24'h123456, 24'h654321, 24'h0F0F0F);
                    hit_sidx   = '0;
                end
                if (stall_at == hs && pix_valid && stall_cnt < 10) begin
                    pix_ready = 1'b0;
                    stall_cnt++;
                    checkOutput("stall_valid", 96'(pix_valid), 96'(1));
                    checkOutput("stall_x", 96'(pix_x), 96'(hs % TILE_W));
                    checkOutput("stall_color", 96'(pix_color), 96'(exp_color(hs)));
                end else begin
                    pix_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (pix_valid && pix_ready && hs < NUM_PIX) begin
                    checkOutput("pix_x", 96'(pix_x), 96'(hs % TILE_W));
                    checkOutput("pix_y", 96'(pix_y), 96'(hs / TILE_W));
                    checkOutput("pix_color", 96'(pix_color), 96'(exp_color(hs)));
                    for (int c = 0; c < COLORS; c++) obs[hs][c] = pix_color[c];
                    hs++;
                end
                @(posedge clk);
                #1;
                cycles++;
            end
        end
        hit_valid = 1'b0;
        pix_ready = 1'b0;
        checkOutput("flush_finished", 96'(finished), 96'(1));
        checkOutput("pixel_count", 96'(hs), 96'(NUM_PIX));
        checkOutput("halt_low_in_resolve", 96'(halt_bad), 96'(0));
        checkOutput("halt_after_flush", 96'(halt_RnnnnL), 96'(1));
        checkOutput("valid_after_flush", 96'(pix_valid), 96'(0));
        @(posedge clk);
        #1;
        checkOutput("flush_done_single", 96'(flush_done), 96'(0));
        model_clear();
    endtask

    initial begin
        rst       = 1'b1;
        hit_valid = 1'b0;
        flush_req = 1'b0;
        pix_ready = 1'b0;
        hit_pos   = '0;
        hit_color = '0;
        hit_sidx  = '0;
        model_clear();

        vecs[0] = '{"hit_3_2",      24'hC00,    24'h800,  24'd100,    24'd400,    0, 3, 2, 24'd100};
        vecs[1] = '{"wrap_x_11_5",  24'h2E00,   24'h000,  24'd5,      24'd40,     1, 3, 0, 24'd10};
        vecs[2] = '{"wrap_y_13",    24'h000,    24'h3400, 24'd9,      24'd8,      3, 0, 5, 24'd2};
        vecs[3] = '{"max_color",    24'h1FFF,   24'h1C00, 24'd0,      24'hFFFFFF, 2, 7, 7, 24'h3FFFFF};
        vecs[4] = '{"z_far_reject", 24'h400,    24'h400,  24'hFFFFFF, 24'd1000,   0, 1, 1, 24'd0};
        vecs[5] = '{"high_bits",    24'h800800, 24'h1000, 24'hFFFFFE, 24'd7,      0, 2, 4, 24'd1};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_halt", 96'(halt_RnnnnL), 96'(1));
        checkOutput("reset_pix_valid", 96'(pix_valid), 96'(0));
        checkOutput("reset_pix_x", 96'(pix_x), 96'(0));
        checkOutput("reset_pix_y", 96'(pix_y), 96'(0));
        checkOutput("reset_pix_color", 96'(pix_color), 96'(0));
        checkOutput("reset_flush_done", 96'(flush_done), 96'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] immediate flush of empty tile");
        run_flush(1'b0, -1, -1, 1'b0, 1'b0);

        $display("[TB] table-driven single hits");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].xp, vecs[i].yp, vecs[i].zv, mk_color(vecs[i].r, 24'd0, 24'd0), vecs[i].sidx);
            run_flush(1'b0, -1, -1, 1'b0, 1'b0);
            checkOutput(vecs[i].name, 96'(obs[vecs[i].ey * TILE_W + vecs[i].ex][0]), 96'(vecs[i].er));
        end

        $display("[TB] four samples in one pixel");
        applyStimulus(24'hC00, 24'h800, 24'd100, mk_color(24'd400, 24'd0, 24'd0), 0);
        applyStimulus(24'hC00, 24'h800, 24'd100, mk_color(24'd0, 24'd0, 24'd0), 1);
        applyStimulus(24'hC00, 24'h800, 24'd100, mk_color(24'd0, 24'd0, 24'd0), 2);
        applyStimulus(24'hC00, 24'h800, 24'd100, mk_color(24'd0, 24'd0, 24'd0), 3);
        run_flush(1'b0, -1, -1, 1'b0, 1'b0);
        checkOutput("four_hit_avg", 96'(obs[2 * TILE_W + 3][0]), 96'(100));

        $display("[TB] strict-less depth test, back to back");
        for (int s = 0; s < NUM_SAMPLES; s++) begin
            applyStimulus(24'h1400, 24'h1800, 24'd50, mk_color(24'd7, 24'd0, 24'd0), s);
            applyStimulus(24'h1400, 24'h1800, 24'd80, mk_color(24'd9, 24'd0, 24'd0), s);
            applyStimulus(24'h1400, 24'h1800, 24'd50, mk_color(24'd5, 24'd0, 24'd0), s);
        end
        run_flush(1'b0, -1, -1, 1'b0, 1'b0);
        checkOutput("equal_z_keeps", 96'(obs[6 * TILE_W + 5][0]), 96'(7));

        $display("[TB] stall, random ready, hits while halted");
        random_hits(60);
        run_flush(1'b1, 17, -1, 1'b1, 1'b0);
        run_flush(1'b0, -1, -1, 1'b0, 1'b0);

        $display("[TB] random rounds with hit alongside flush_req");
        for (int r = 0; r < 3; r++) begin
            random_hits(150);
            hit_pos[0] = SIGFIG'($urandom);
            hit_pos[1] = SIGFIG'($urandom);
            hit_pos[2] = SIGFIG'($urandom_range(0, 40));
            hit_color  = mk_color(SIGFIG'($urandom), SIGFIG'($urandom), SIGFIG'($urandom));
            hit_sidx   = SIDX_W'($urandom_range(0, NUM_SAMPLES - 1));
            run_flush(1'b1, -1, -1, 1'b0, 1'b1);
        end

        $display("[TB] reset in the middle of a resolve");
        applyStimulus(24'h0000, 24'h1400, 24'd3, mk_color(24'd800, 24'd44, 24'd12), 0);
        applyStimulus(24'h1C00, 24'h1C00, 24'd3, mk_color(24'd900, 24'd88, 24'd16), 2);
        random_hits(40);
        run_flush(1'b0, -1, 20, 1'b0, 1'b0);
        run_flush(1'b0, -1, -1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
